imem_loader: RTL

Boot-time controller that fills instruction memory from a byte stream and holds the CPU in reset until a valid image is loaded. It accepts a length-prefixed, little-endian word image over a valid/ready byte interface and assembles 32-bit words. It issues one synchronous instruction-memory write per word, then releases the CPU core, whose PC then starts fetching from byte address 0. It sits between the external link (UART/JTAG byte receiver) and the instruction memory write port / core reset.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Receives a length-prefixed little-endian word image over a valid/ready byte
// link, writes one 32-bit word per imem_we pulse and releases the core when
// the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W   = $clog2(IMEM_DEPTH) + 1;
  localparam logic [7:0]  MAX_LEN = 8'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   word_idx, idx_d;
  logic [IDX_W-1:0]   n_words, nw_d;
  logic [1:0]         lane, lane_d;
  logic [23:0]        byte_buf, buf_d;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;
  logic               ready_d, hold_d, busy_d, done_d, err_d;
  logic               drain;
  logic               accept_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum, csum_d;
`endif

  assign accept_c = byte_valid && byte_ready;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      n_words    <= '0;
      lane       <= '0;
      byte_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
      word_idx   <= idx_d;
      n_words    <= nw_d;
      lane       <= lane_d;
      byte_buf   <= buf_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      byte_ready <= ready_d;
      cpu_hold   <= hold_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

  // Next-state, word assembly and next output values
  always_comb begin
    state_d = state;
    idx_d   = word_idx;
    nw_d    = n_words;
    lane_d  = lane;
    buf_d   = byte_buf;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    drain   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum;
`endif

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          lane_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept_c) begin
          if (byte_data == 8'd0 || byte_data > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            nw_d    = IDX_W'(byte_data);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Only reachable without checksum: one cycle after the last write
        if (word_idx == n_words) begin
          state_d = S_DONE;
        end else if (accept_c) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum ^ byte_data;
`endif
          lane_d = lane + 2'd1;
          case (lane)
            2'd0: buf_d[7:0]   = byte_data;
            2'd1: buf_d[15:8]  = byte_data;
            2'd2: buf_d[23:16] = byte_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = ADDR_W'({word_idx, 2'b00});
              wdata_d = {byte_data, byte_buf};
              idx_d   = word_idx + 1'b1;
              if (idx_d == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CSUM;
`else
                drain   = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_c) begin
          state_d = (byte_data == csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered; ready drops while the last word drains
    busy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    ready_d = busy_d && !drain;
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

endmodule
